// File: rtl/pc_sequencer_if.sv
// Control/status bundle between a sequencer and whatever drives it.
// The master issues the control requests; the slave returns the registered PC and status.
interface pc_sequencer_if #(
  parameter int unsigned D  = 12,
  parameter int unsigned SD = 4
);
  localparam int unsigned DW = $clog2(SD + 1);

  logic          start;
  logic          stall;
  logic          halt;
  logic          jump_en;
  logic [1:0]    jump_mode;
  logic [D-1:0]  target;
  logic          call_en;
  logic          ret_en;
  logic [D-1:0]  prog_ctr;
  logic          running;
  logic          done;
  logic          stack_err;
  logic [DW-1:0] stack_depth;

  modport master (
    output start, stall, halt, jump_en, jump_mode, target, call_en, ret_en,
    input  prog_ctr, running, done, stack_err, stack_depth
  );

  modport slave (
    input  start, stall, halt, jump_en, jump_mode, target, call_en, ret_en,
    output prog_ctr, running, done, stack_err, stack_depth
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer with relative/absolute jumps and a small return stack.
// One action per cycle in RUN; all outputs come straight from registers.
module pc_sequencer #(
  parameter int unsigned D  = 12,
  parameter int unsigned SD = 4
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);
  localparam int unsigned DW = $clog2(SD + 1);
  localparam int unsigned AW = (SD > 1) ? $clog2(SD) : 1;
  localparam logic [DW-1:0] Full = DW'(SD);

  typedef enum logic [1:0] {StIdle, StRun, StDone, StErr} state_e;

  state_e        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d, pc_inc;
  logic [DW-1:0] depth_q, depth_d;
  logic          err_q, err_d;
  logic          push_en;
  logic [AW-1:0] top_idx, push_idx;
  logic [D-1:0]  stack_q [SD];

  assign pc_inc   = pc_q + D'(1);
  assign top_idx  = AW'(depth_q - DW'(1));
  assign push_idx = AW'(depth_q);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (bus.start) begin
      state_d = StRun;
      pc_d    = '0;
      depth_d = '0;
      err_d   = 1'b0;
    end else if (state_q == StRun && !bus.stall) begin
      if (bus.halt) begin
        state_d = StDone;
      end else if (bus.ret_en) begin
        if (depth_q == '0) begin
          err_d   = 1'b1;
          state_d = StErr;
        end else begin
          pc_d    = stack_q[top_idx];
          depth_d = depth_q - DW'(1);
        end
      end else if (bus.call_en) begin
        if (depth_q == Full) begin
          err_d   = 1'b1;
          state_d = StErr;
        end else begin
          push_en = 1'b1;
          pc_d    = bus.target;
          depth_d = depth_q + DW'(1);
        end
      end else if (bus.jump_en) begin
        case (bus.jump_mode)
          2'b00:   pc_d = pc_q + bus.target;
          2'b01:   pc_d = pc_q - bus.target;
          2'b10:   pc_d = bus.target;
          default: pc_d = pc_inc;
        endcase
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Entry contents need no reset: only depth_q says which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign bus.prog_ctr    = pc_q;
  assign bus.running     = (state_q == StRun);
  assign bus.done        = (state_q == StDone) || (state_q == StErr);
  assign bus.stack_err   = err_q;
  assign bus.stack_depth = depth_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for single-cycle behaviour,
// hand-written sequences for reset handling.
module tb_pc_sequencer;
  localparam int unsigned D  = 12;
  localparam int unsigned SD = 4;
  localparam int unsigned DW = 3;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.D(D), .SD(SD)) bus ();

  pc_sequencer #(.D(D), .SD(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string         name;
    logic          start, stall, halt, jump_en;
    logic [1:0]    mode;
    logic [D-1:0]  target;
    logic          call_en, ret_en;
    logic [D-1:0]  pc;
    logic          run, dn, err;
    logic [DW-1:0] dep;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, logic s, logic st, logic h, logic j, logic [1:0] m,
                              logic [D-1:0] t, logic c, logic r, logic [D-1:0] pc,
                              logic ru, logic dn, logic er, logic [DW-1:0] dp);
    vec_t v;
    v.name = n; v.start = s; v.stall = st; v.halt = h; v.jump_en = j; v.mode = m;
    v.target = t; v.call_en = c; v.ret_en = r; v.pc = pc; v.run = ru; v.dn = dn;
    v.err = er; v.dep = dp;
    vecs.push_back(v);
  endfunction

  task automatic drive(logic s, logic st, logic h, logic j, logic [1:0] m, logic [D-1:0] t,
                       logic c, logic r);
    bus.start = s; bus.stall = st; bus.halt = h; bus.jump_en = j; bus.jump_mode = m;
    bus.target = t; bus.call_en = c; bus.ret_en = r;
  endtask

  task automatic check(string n, logic [D-1:0] pc, logic ru, logic dn, logic er,
                       logic [DW-1:0] dp);
    logic [D+5:0] got, exp;
    got = {bus.prog_ctr, bus.running, bus.done, bus.stack_err, bus.stack_depth};
    exp = {pc, ru, dn, er, dp};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got pc=%0d run=%0b done=%0b err=%0b depth=%0d, want pc=%0d run=%0b done=%0b err=%0b depth=%0d",
               n, bus.prog_ctr, bus.running, bus.done, bus.stack_err, bus.stack_depth,
               pc, ru, dn, er, dp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   name          st sl ha je mode   tgt  ca re   pc  run dn er dep
    add("start",        1, 0, 0, 0, 2'b00,   0, 0, 0,    0, 1, 0, 0, 0);
    add("inc1",         0, 0, 0, 0, 2'b00,   0, 0, 0,    1, 1, 0, 0, 0);
    add("inc2",         0, 0, 0, 0, 2'b00,   0, 0, 0,    2, 1, 0, 0, 0);
    add("inc3",         0, 0, 0, 0, 2'b00,   0, 0, 0,    3, 1, 0, 0, 0);
    add("jabs10",       0, 0, 0, 1, 2'b10,  10, 0, 0,   10, 1, 0, 0, 0);
    add("jback4",       0, 0, 0, 1, 2'b01,   4, 0, 0,    6, 1, 0, 0, 0);
    add("jabs2",        0, 0, 0, 1, 2'b10,   2, 0, 0,    2, 1, 0, 0, 0);
    add("jfwd_wrap",    0, 0, 0, 1, 2'b00, 4095, 0, 0,   1, 1, 0, 0, 0);
    add("jabs5",        0, 0, 0, 1, 2'b10,   5, 0, 0,    5, 1, 0, 0, 0);
    add("call100",      0, 0, 0, 0, 2'b00, 100, 1, 0,  100, 1, 0, 0, 1);
    add("ret6",         0, 0, 0, 0, 2'b00,   0, 0, 1,    6, 1, 0, 0, 0);
    add("jmode11",      0, 0, 0, 1, 2'b11,  77, 0, 0,    7, 1, 0, 0, 0);
    add("stall_call",   0, 1, 0, 1, 2'b10,  50, 1, 0,    7, 1, 0, 0, 0);
    add("halt_stall",   0, 1, 1, 0, 2'b00,   0, 0, 0,    7, 1, 0, 0, 0);
    add("halt",         0, 0, 1, 0, 2'b00,   0, 0, 0,    7, 0, 1, 0, 0);
    add("done_jump",    0, 0, 0, 1, 2'b10,  50, 0, 0,    7, 0, 1, 0, 0);
    add("done_call",    0, 0, 0, 0, 2'b00,   9, 1, 0,    7, 0, 1, 0, 0);
    add("restart",      1, 0, 0, 0, 2'b00,   0, 0, 0,    0, 1, 0, 0, 0);
    add("callret_uf",   0, 0, 0, 0, 2'b00,  33, 1, 1,    0, 0, 1, 1, 0);
    add("err_jump",     0, 0, 0, 1, 2'b10,  20, 0, 0,    0, 0, 1, 1, 0);
    add("restart2",     1, 0, 0, 0, 2'b00,   0, 0, 0,    0, 1, 0, 0, 0);
    add("call_1",       0, 0, 0, 0, 2'b00, 200, 1, 0,  200, 1, 0, 0, 1);
    add("call_2",       0, 0, 0, 0, 2'b00, 200, 1, 0,  200, 1, 0, 0, 2);
    add("call_3",       0, 0, 0, 0, 2'b00, 200, 1, 0,  200, 1, 0, 0, 3);
    add("call_4",       0, 0, 0, 0, 2'b00, 200, 1, 0,  200, 1, 0, 0, 4);
    add("call_5_of",    0, 0, 0, 0, 2'b00, 300, 1, 0,  200, 0, 1, 1, 4);
    add("restart3",     1, 0, 1, 0, 2'b00,   0, 1, 1,    0, 1, 0, 0, 0);
    add("call300",      0, 0, 0, 0, 2'b00, 300, 1, 0,  300, 1, 0, 0, 1);
    add("call400",      0, 0, 0, 0, 2'b00, 400, 1, 0,  400, 1, 0, 0, 2);
    add("ret301",       0, 0, 0, 0, 2'b00,   0, 0, 1,  301, 1, 0, 0, 1);
    add("ret1",         0, 0, 0, 0, 2'b00,   0, 0, 1,    1, 1, 0, 0, 0);
    add("jabs4095",     0, 0, 0, 1, 2'b10, 4095, 0, 0, 4095, 1, 0, 0, 0);
    add("inc_wrap",     0, 0, 0, 0, 2'b00,   0, 0, 0,    0, 1, 0, 0, 0);

    drive(0, 0, 0, 0, 2'b00, 0, 0, 0);
    reset = 1'b0;
    #12;
    check("reset_state", 0, 0, 0, 0, 0);
    reset = 1'b1;
    drive(0, 0, 0, 1, 2'b10, 55, 1, 0);
    step();
    check("idle_hold", 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].stall, vecs[i].halt, vecs[i].jump_en, vecs[i].mode,
            vecs[i].target, vecs[i].call_en, vecs[i].ret_en);
      step();
      check(vecs[i].name, vecs[i].pc, vecs[i].run, vecs[i].dn, vecs[i].err, vecs[i].dep);
    end

    // Asynchronous reset between edges while a call is pending at depth 2.
    drive(1, 0, 0, 0, 2'b00, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 2'b00, 10, 1, 0);
    step();
    drive(0, 0, 0, 0, 2'b00, 37, 1, 0);
    step();
    check("pre_reset", 37, 1, 0, 0, 2);
    drive(0, 0, 0, 0, 2'b00, 99, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 0, 0, 0, 0, 0);
    step();
    check("reset_held", 0, 0, 0, 0, 0);
    reset = 1'b1;
    drive(0, 0, 0, 1, 2'b10, 5, 1, 0);
    step();
    check("post_reset_idle1", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 2'b00, 0, 0, 1);
    step();
    check("post_reset_idle2", 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 2'b00, 0, 0, 0);
    step();
    check("post_reset_start", 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0);
    step();
    check("post_reset_inc", 1, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
